// File: rtl/softmax_outp_writeback_pkg.sv
// Shared parameters and state type for the softmax output writeback block.
// The lane and address geometry matches the softmax core.
package softmax_outp_writeback_pkg;

  localparam int DATAWIDTH  = 16;
  localparam int NUM        = 4;
  localparam int ADDRSIZE   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int ROW_W      = DATAWIDTH * NUM;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } wb_state_e;

endpackage

// File: rtl/softmax_outp_writeback_fifo.sv
// Small synchronous row FIFO with a flush. It accepts a push into a full FIFO
// when a pop happens in the same cycle.
module softmax_wb_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every read that matters.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/softmax_outp_writeback.sv
// Captures softmax result rows, buffers them and writes them to output memory
// at consecutive addresses through a grant-arbitrated port.
module softmax_outp_writeback
  import softmax_outp_writeback_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   init,
  input  logic [ADDRSIZE-1:0]    dst_start_addr,
  input  logic                   sm_done,
  input  logic [ROW_W-1:0]       sm_outp,
  input  logic                   wr_gnt,
  output logic                   wr_en,
  output logic [ADDRSIZE-1:0]    wr_addr,
  output logic [ROW_W-1:0]       wr_data,
  output logic [ADDRSIZE:0]      rows_written,
  output logic                   wb_done,
  output logic                   overflow,
  output logic                   addr_wrap
);

  wb_state_e            state_q, state_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDRSIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [ROW_W-1:0]     wr_data_q, wr_data_d;
  logic [ADDRSIZE-1:0]  next_addr_q, next_addr_d;
  logic [ADDRSIZE:0]    rows_q, rows_d;
  logic                 wb_done_q, wb_done_d;
  logic                 overflow_q, overflow_d;
  logic                 addr_wrap_q, addr_wrap_d;

  logic                 fifo_push, pop_fire, fifo_full, fifo_empty;
  logic [ROW_W-1:0]     fifo_rdata;

  // init flushes the FIFO and suppresses any pop in the same cycle.
  assign fifo_push = sm_done && !init && (state_q == ST_ARMED || state_q == ST_RUN);
  assign pop_fire  = !fifo_empty && wr_gnt && !init;

  softmax_wb_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (init),
    .push  (fifo_push),
    .pop   (wr_gnt && !init),
    .wdata (sm_outp),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    wr_en_d     = pop_fire;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    next_addr_d = next_addr_q;
    rows_d      = rows_q;
    overflow_d  = overflow_q;
    addr_wrap_d = addr_wrap_q;

    if (pop_fire) begin
      wr_addr_d   = next_addr_q;
      wr_data_d   = fifo_rdata;
      next_addr_d = next_addr_q + ADDRSIZE'(1);
      if (next_addr_q == '1) addr_wrap_d = 1'b1;
      if (rows_q != '1) rows_d = rows_q + (ADDRSIZE+1)'(1);
    end

    if (fifo_push && fifo_full && !pop_fire) overflow_d = 1'b1;

    case (state_q)
      ST_ARMED: if (sm_done) state_d = ST_RUN;
      ST_RUN:   if (!sm_done) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !pop_fire) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = state_q;
    endcase

    if (init) begin
      state_d     = ST_ARMED;
      next_addr_d = dst_start_addr;
      rows_d      = '0;
      overflow_d  = 1'b0;
      addr_wrap_d = 1'b0;
    end

    // Registered so the pulse lines up with the cycle spent in DONE.
    wb_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      next_addr_q <= '0;
      rows_q      <= '0;
      wb_done_q   <= 1'b0;
      overflow_q  <= 1'b0;
      addr_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      next_addr_q <= next_addr_d;
      rows_q      <= rows_d;
      wb_done_q   <= wb_done_d;
      overflow_q  <= overflow_d;
      addr_wrap_q <= addr_wrap_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign rows_written = rows_q;
  assign wb_done      = wb_done_q;
  assign overflow     = overflow_q;
  assign addr_wrap    = addr_wrap_q;

endmodule
